// File: rtl/serial_subtractor.sv
// Bit-serial W-bit two's-complement subtractor: diff = a - b - bi, LSB first,
// one full-subtract step per clock, with borrow-out and signed-overflow flags.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  // state | meaning
  // IDLE  | waiting for start; diff/bout/ovf hold the last result
  // RUN   | one bit per edge; completes on the edge where cnt == W-1

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic [W-1:0]   sr;
  logic           br;
  logic [CW-1:0]  cnt;

  logic           d_bit;
  logic           br_next;
  logic [W-1:0]   sr_next;

  always_comb begin
    d_bit   = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (sb[0] & br) | (~sa[0] & br);
    // Shift the new bit in from the MSB side; written this way so W=1 needs no special case.
    sr_next = W'({d_bit, sr} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bi;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          sr  <= sr_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            // br here is still the borrow into the MSB position.
            diff  <= sr_next;
            bout  <= br_next;
            ovf   <= br ^ br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor at W = 8, 1, 4, 16,
// compared against an integer-arithmetic reference of a - b - bi.
module tb_serial_subtractor;

  localparam int NI = 4;
  localparam int WS [NI] = '{8, 1, 4, 16};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [NI];
  logic [15:0] a_v     [NI];
  logic [15:0] b_v     [NI];
  logic        bi_v    [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic [15:0] diff_v  [NI];
  logic        bout_v  [NI];
  logic        ovf_v   [NI];
  logic [17:0] last_res [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WG = WS[g];
    logic [WG-1:0] d_w;
    logic          bsy_w, dn_w, bo_w, ov_w;
    serial_subtractor #(.W(WG)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .a     (a_v[g][WG-1:0]),
      .b     (b_v[g][WG-1:0]),
      .bi    (bi_v[g]),
      .busy  (bsy_w),
      .done  (dn_w),
      .diff  (d_w),
      .bout  (bo_w),
      .ovf   (ov_w)
    );
    assign busy_v[g] = bsy_w;
    assign done_v[g] = dn_w;
    assign diff_v[g] = 16'(d_w);
    assign bout_v[g] = bo_w;
    assign ovf_v[g]  = ov_w;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {bout, ovf, diff} from plain integer arithmetic on w-bit operands.
  function automatic logic [17:0] ref_sub(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic biv);
    longint m, half, ua, ub, ib, r, sa_i, sb_i, rs;
    logic   bo, ov;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    ib   = biv ? 1 : 0;
    r    = ua - ub - ib;
    sa_i = (ua >= half) ? ua - (m + 1) : ua;
    sb_i = (ub >= half) ? ub - (m + 1) : ub;
    rs   = sa_i - sb_i - ib;
    bo   = (ua < ub + ib);
    ov   = (rs < -half) || (rs >= half);
    return {bo, ov, 16'(r & m)};
  endfunction

  function automatic logic [17:0] res_of(input int idx);
    return {bout_v[idx], ovf_v[idx], diff_v[idx]};
  endfunction

  task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv, input logic biv);
    logic [17:0] exp;
    int          n;
    bit          seen;
    exp = ref_sub(WS[idx], av, bv, biv);
    @(negedge clk);
    a_v[idx] = av; b_v[idx] = bv; bi_v[idx] = biv; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom); bi_v[idx] = 1'($urandom);
    check_val("busy_after_accept", 32'(busy_v[idx]), 32'd1);
    n = 0;
    seen = 0;
    while (!seen && n < WS[idx] + 4) begin
      @(posedge clk); #1;
      n++;
      if (done_v[idx]) seen = 1;
      else check_val("result_hold_in_run", 32'(res_of(idx)), 32'(last_res[idx]));
    end
    check_val("done_seen", 32'(seen), 32'd1);
    check_val("done_latency", 32'(n), 32'(WS[idx]));
    check_val("diff", 32'(diff_v[idx]), 32'(exp[15:0]));
    check_val("bout", 32'(bout_v[idx]), 32'(exp[17]));
    check_val("ovf", 32'(ovf_v[idx]), 32'(exp[16]));
    check_val("busy_at_done", 32'(busy_v[idx]), 32'd0);
    last_res[idx] = exp;
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(done_v[idx]), 32'd0);
    check_val("result_after_done", 32'(res_of(idx)), 32'(exp));
  endtask

  task automatic run_back_to_back(input int idx, input int n_ops);
    int          w;
    int          ph;
    logic [17:0] q[$];
    logic [17:0] exp;
    w = WS[idx];
    @(negedge clk);
    start_v[idx] = 1'b1;
    a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom); bi_v[idx] = 1'($urandom);
    for (int e = 0; e < n_ops * (w + 1); e++) begin
      @(posedge clk);
      ph = e % (w + 1);
      if (ph == 0) q.push_back(ref_sub(w, a_v[idx], b_v[idx], bi_v[idx]));
      #1;
      check_val("b2b_busy", 32'(busy_v[idx]), 32'(ph != w));
      check_val("b2b_done", 32'(done_v[idx]), 32'(ph == w));
      if (ph == w) begin
        exp = q.pop_front();
        check_val("b2b_result", 32'(res_of(idx)), 32'(exp));
        last_res[idx] = exp;
      end else begin
        check_val("b2b_hold", 32'(res_of(idx)), 32'(last_res[idx]));
      end
      a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom); bi_v[idx] = 1'($urandom);
    end
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic run_reset_mid(input int idx);
    int n_done;
    @(negedge clk);
    a_v[idx] = 16'h33; b_v[idx] = 16'h11; bi_v[idx] = 1'b0; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy_v[idx]), 32'd0);
    check_val("rst_done", 32'(done_v[idx]), 32'd0);
    check_val("rst_result", 32'(res_of(idx)), 32'd0);
    for (int i = 0; i < NI; i++) last_res[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (WS[idx] + 3) begin
      @(posedge clk); #1;
      if (done_v[idx]) n_done++;
    end
    check_val("no_done_after_rst", 32'(n_done), 32'd0);
    check_val("idle_after_rst", 32'(busy_v[idx]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; bi_v[i] = 1'b0; last_res[i] = '0;
    end
    #12;
    for (int i = 0; i < NI; i++) begin
      check_val("reset_busy", 32'(busy_v[i]), 32'd0);
      check_val("reset_done", 32'(done_v[i]), 32'd0);
      check_val("reset_result", 32'(res_of(i)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 16'h5A, 16'h3C, 1'b0);
    run_op(0, 16'h00, 16'h01, 1'b0);
    run_op(0, 16'h80, 16'h01, 1'b0);
    run_op(0, 16'h7F, 16'hFF, 1'b0);
    run_op(0, 16'h10, 16'h10, 1'b1);
    run_op(0, 16'h00, 16'h00, 1'b0);
    run_op(1, 16'h0, 16'h0, 1'b1);
    run_op(1, 16'h1, 16'h0, 1'b1);
    run_op(3, 16'h8000, 16'h0001, 1'b0);

    run_back_to_back(0, 3);
    run_back_to_back(1, 3);

    run_op(0, 16'h5A, 16'h3C, 1'b0);
    run_reset_mid(0);
    run_op(0, 16'hC3, 16'h4D, 1'b1);

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < ((i == 0) ? 200 : 1000); k++)
        run_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
